// File: rtl/rcpu_intc.sv
// rcpu_intc: fixed-priority interrupt controller sitting in front of the RCPU
// core interrupt port. Collects NIRQ request lines plus software triggers,
// presents one request at a time on irq/intAddr, retires it on turnOffIRQ and
// waits for an end-of-interrupt write before presenting the next one.
// Configuration macro: RCPU_INTC_EDGE_EN (defined = edge-triggered lines,
// undefined = level-triggered lines).
module rcpu_intc #(
    parameter int unsigned  NIRQ       = 8,
    parameter int unsigned  N          = 32,
    parameter logic [N-1:0] VEC_BASE   = N'(32'h0000_F000),
    parameter int unsigned  VEC_STRIDE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irqIn,
    output logic            irq,
    output logic [N-1:0]    intAddr,
    input  logic            turnOffIRQ,
    input  logic            regWE,
    input  logic [1:0]      regSel,
    input  logic [15:0]     regWData,
    output logic [15:0]     regRData
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Only bits below NIRQ exist; everything above reads 0 and ignores writes.
    localparam logic [15:0] LINE_MASK = 16'((32'd1 << NIRQ) - 32'd1);

    // Lowest set index wins (bit 0 is the highest priority).
    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_mask;
    logic [15:0]    r_pending;
    logic [3:0]     r_id;
    logic           r_irq;
    logic [N-1:0]   r_int_addr;

    logic [15:0]    w_irq_in;
    logic [15:0]    w_hw_set;
    logic [15:0]    w_sw_set;
    logic [15:0]    w_w1c;
    logic [15:0]    w_ack_clr;
    logic [15:0]    w_req;
    logic [3:0]     w_next_id;
    logic           w_take;
    logic           w_ack;
    logic           w_eoi;
    logic [15:0]    w_rdata;

    assign w_irq_in = 16'(irqIn);

`ifdef RCPU_INTC_EDGE_EN
    logic [15:0] r_irq_prev;

    // Previous sample of the request lines, used to detect rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= 16'd0;
        end else begin
            r_irq_prev <= w_irq_in;
        end
    end

    assign w_hw_set = w_irq_in & ~r_irq_prev;
`else
    assign w_hw_set = w_irq_in;
`endif

    assign w_sw_set  = (regWE && (regSel == 2'd3)) ? (regWData & LINE_MASK) : 16'd0;
    assign w_w1c     = (regWE && (regSel == 2'd1)) ? regWData : 16'd0;
    assign w_eoi     = regWE && (regSel == 2'd2);
    assign w_req     = r_pending & r_mask;
    assign w_next_id = lowest_index(w_req);
    assign w_take    = (r_state == ST_IDLE) && (w_req != 16'd0);
    assign w_ack     = (r_state == ST_REQ) && turnOffIRQ;
    assign w_ack_clr = w_ack ? (16'd1 << r_id) : 16'd0;

    // Next-state logic: IDLE -> REQ on an enabled pending line, REQ -> SERVICE
    // on ack, SERVICE -> IDLE on EOI; EOI or ack in any other state is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req != 16'd0) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (turnOffIRQ) begin
                    w_state_nxt = ST_SERVICE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (w_eoi) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state plus the presented request (id/address frozen while in REQ).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_irq      <= 1'b0;
            r_id       <= 4'd0;
            r_int_addr <= VEC_BASE;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == ST_REQ);
            if (w_take) begin
                r_id       <= w_next_id;
                r_int_addr <= VEC_BASE + (N'(w_next_id) * N'(VEC_STRIDE));
            end
        end
    end

    // MASK and PENDING; a set in the same cycle as a clear always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask    <= 16'd0;
            r_pending <= 16'd0;
        end else begin
            if (regWE && (regSel == 2'd0)) begin
                r_mask <= regWData & LINE_MASK;
            end
            r_pending <= ((r_pending & ~(w_w1c | w_ack_clr)) | w_hw_set | w_sw_set)
                         & LINE_MASK;
        end
    end

    // Register read mux; SWTRIG is write-only and reads back as zero.
    always_comb begin
        w_rdata = 16'd0;
        case (regSel)
            2'd0:    w_rdata = r_mask;
            2'd1:    w_rdata = r_pending;
            2'd2:    w_rdata = {(r_state != ST_IDLE), r_state, 9'd0, r_id};
            2'd3:    w_rdata = 16'd0;
            default: w_rdata = 16'd0;
        endcase
    end

    assign irq      = r_irq;
    assign intAddr  = r_int_addr;
    assign regRData = w_rdata;

endmodule

// File: tb/tb_rcpu_intc.sv
// Directed self-checking bench for rcpu_intc (default parameters).
// Expectations for the held-line test follow RCPU_INTC_EDGE_EN when defined.
module tb_rcpu_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irqIn;
    logic        irq;
    logic [31:0] intAddr;
    logic        turnOffIRQ;
    logic        regWE;
    logic [1:0]  regSel;
    logic [15:0] regWData;
    logic [15:0] regRData;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] R_MASK = 2'd0, R_PEND = 2'd1, R_STAT = 2'd2, R_SWTRIG = 2'd3;

    rcpu_intc dut (
        .clk        (clk),
        .rst        (rst),
        .irqIn      (irqIn),
        .irq        (irq),
        .intAddr    (intAddr),
        .turnOffIRQ (turnOffIRQ),
        .regWE      (regWE),
        .regSel     (regSel),
        .regWData   (regWData),
        .regRData   (regRData)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] sel, input logic [15:0] data);
        regWE    = 1'b1;
        regSel   = sel;
        regWData = data;
        tick();
        regWE    = 1'b0;
        regWData = 16'd0;
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        regSel = sel;
        #1;
        check_val(tag, 32'(regRData), 32'(exp));
    endtask

    task automatic ack();
        turnOffIRQ = 1'b1;
        tick();
        turnOffIRQ = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        irqIn      = 8'h00;
        turnOffIRQ = 1'b0;
        regWE      = 1'b0;
        regSel     = 2'd0;
        regWData   = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_addr", intAddr, 32'h0000_F000);
        reg_chk("rst_mask", R_MASK, 16'h0000);
        reg_chk("rst_pend", R_PEND, 16'h0000);
        reg_chk("rst_stat", R_STAT, 16'h0000);

        // Single line 0: two-cycle latency, ack, EOI
        reg_wr(R_MASK, 16'h0001);
        reg_chk("t1_mask", R_MASK, 16'h0001);
        irqIn = 8'h01;
        tick();
        irqIn = 8'h00;
        check_val("t1_irq_lat1", 32'(irq), 32'd0);
        reg_chk("t1_pend", R_PEND, 16'h0001);
        tick();
        check_val("t1_irq", 32'(irq), 32'd1);
        check_val("t1_addr", intAddr, 32'h0000_F000);
        reg_chk("t1_stat_req", R_STAT, 16'hA000);
        ack();
        check_val("t1_irq_ack", 32'(irq), 32'd0);
        reg_chk("t1_stat_svc", R_STAT, 16'hC000);
        reg_chk("t1_pend_ack", R_PEND, 16'h0000);
        reg_wr(R_STAT, 16'h0000);
        reg_chk("t1_stat_eoi", R_STAT, 16'h0000);

        // Priority: lines 5 and 2 together
        reg_wr(R_MASK, 16'h00FF);
        irqIn = 8'h24;
        tick();
        irqIn = 8'h00;
        tick();
        check_val("t2_irq_a", 32'(irq), 32'd1);
        check_val("t2_addr_a", intAddr, 32'h0000_F004);
        reg_chk("t2_stat_a", R_STAT, 16'hA002);
        ack();
        reg_chk("t2_pend_a", R_PEND, 16'h0020);
        tick();
        check_val("t2_no_b2b", 32'(irq), 32'd0);
        reg_wr(R_STAT, 16'h0000);
        check_val("t2_irq_eoi", 32'(irq), 32'd0);
        tick();
        check_val("t2_irq_b", 32'(irq), 32'd1);
        check_val("t2_addr_b", intAddr, 32'h0000_F00A);
        reg_chk("t2_stat_b", R_STAT, 16'hA005);
        ack();
        reg_wr(R_STAT, 16'h0000);

        // Masked line stays pending, then enabling it raises irq
        reg_wr(R_MASK, 16'h0000);
        irqIn = 8'h08;
        tick();
        irqIn = 8'h00;
        tick();
        reg_chk("t3_pend", R_PEND, 16'h0008);
        check_val("t3_irq_masked", 32'(irq), 32'd0);
        reg_wr(R_MASK, 16'h0008);
        check_val("t3_irq_wr", 32'(irq), 32'd0);
        tick();
        check_val("t3_irq_en", 32'(irq), 32'd1);
        check_val("t3_addr", intAddr, 32'h0000_F006);
        ack();
        irqIn = 8'h08;
        tick();
        irqIn = 8'h00;
        reg_chk("t3_pend_svc", R_PEND, 16'h0008);
        reg_wr(R_PEND, 16'h0008);
        reg_chk("t3_pend_w1c", R_PEND, 16'h0000);
        reg_chk("t3_stat_svc", R_STAT, 16'hC003);
        reg_wr(R_STAT, 16'h0000);
        tick();
        check_val("t3_irq_idle", 32'(irq), 32'd0);

        // Set wins over W1C; software trigger presents id 7
        reg_wr(R_MASK, 16'h0000);
        irqIn = 8'h80;
        reg_wr(R_PEND, 16'h0080);
        irqIn = 8'h00;
        reg_chk("t4_set_wins", R_PEND, 16'h0080);
        reg_wr(R_PEND, 16'h0080);
        reg_chk("t4_w1c", R_PEND, 16'h0000);
        reg_wr(R_SWTRIG, 16'h0080);
        reg_chk("t4_swtrig", R_PEND, 16'h0080);
        reg_chk("t4_swtrig_rd", R_SWTRIG, 16'h0000);
        reg_wr(R_MASK, 16'h0080);
        tick();
        check_val("t4_irq", 32'(irq), 32'd1);
        check_val("t4_addr", intAddr, 32'h0000_F00E);
        reg_chk("t4_stat", R_STAT, 16'hA007);
        // EOI while in REQ is ignored
        reg_wr(R_STAT, 16'h0000);
        reg_chk("t4_eoi_req", R_STAT, 16'hA007);

        // Reset mid-request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_irq", 32'(irq), 32'd0);
        check_val("t5_addr", intAddr, 32'h0000_F000);
        reg_chk("t5_mask", R_MASK, 16'h0000);
        reg_chk("t5_pend", R_PEND, 16'h0000);
        ack();
        reg_chk("t5_stray_ack", R_STAT, 16'h0000);

        // Held-high line 1 through ack and EOI
        reg_wr(R_MASK, 16'h0002);
        irqIn = 8'h02;
        tick();
        tick();
        check_val("t6_irq", 32'(irq), 32'd1);
        check_val("t6_addr", intAddr, 32'h0000_F002);
        ack();
        check_val("t6_irq_ack", 32'(irq), 32'd0);
`ifdef RCPU_INTC_EDGE_EN
        reg_chk("t6_pend_ack", R_PEND, 16'h0000);
`else
        reg_chk("t6_pend_ack", R_PEND, 16'h0002);
`endif
        reg_wr(R_STAT, 16'h0000);
        check_val("t6_irq_eoi", 32'(irq), 32'd0);
        tick();
`ifdef RCPU_INTC_EDGE_EN
        check_val("t6_irq_again", 32'(irq), 32'd0);
`else
        check_val("t6_irq_again", 32'(irq), 32'd1);
`endif
        irqIn = 8'h00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
